// File: rtl/button_evt_pkg.sv
// rtl/button_evt_pkg.sv - controller state encoding and button PIO register map
package button_evt_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_ADDR,
    RD_CAP,
    CLR,
    SETTLE
  } state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

endpackage

// File: rtl/button_evt_fifo.sv
// rtl/button_evt_fifo.sv - first-word fall-through event FIFO; a push into a full
// FIFO succeeds only when a pop frees a slot in the same cycle
module button_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/button_evt_ctrl.sv
// rtl/button_evt_ctrl.sv - services button PIO edge interrupts into an event FIFO;
// BUTTON_EVT_CTRL_TIMESTAMP_EN adds a 16-bit cycle timestamp to each event
module button_evt_ctrl
  import button_evt_pkg::*;
#(
  parameter int              DATA_W     = 4,
  parameter logic [DATA_W-1:0] MASK_INIT = 4'hF,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pio_irq,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DATA_W-1:0] evt_data,
  output logic [15:0]       evt_time,
  output logic              ovf,
  input  logic              ovf_clr
);

  state_t            state;
  logic [DATA_W-1:0] cap_reg;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              unused_rd_hi;

  assign unused_rd_hi = ^avm_readdata[31:DATA_W];

  // Bus outputs are loaded one edge ahead so they line up with the state they
  // belong to; the INIT mask write therefore lands in the first cycle after INIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= INIT;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= PIO_ADDR_DATA;
      avm_writedata  <= '0;
      cap_reg        <= '0;
    end else begin
      case (state)
        INIT: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= PIO_ADDR_MASK;
          avm_writedata  <= 32'(MASK_INIT);
          state          <= IDLE;
        end
        IDLE: begin
          avm_write_n   <= 1'b1;
          avm_writedata <= '0;
          if (pio_irq) begin
            avm_chipselect <= 1'b1;
            avm_address    <= PIO_ADDR_EDGE;
            state          <= RD_ADDR;
          end else begin
            avm_chipselect <= 1'b0;
            avm_address    <= PIO_ADDR_DATA;
          end
        end
        RD_ADDR: begin
          avm_chipselect <= 1'b0;
          state          <= RD_CAP;
        end
        RD_CAP: begin
          cap_reg        <= avm_readdata[DATA_W-1:0];
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_writedata  <= 32'hFFFF_FFFF;
          state          <= CLR;
        end
        CLR: begin
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          avm_address    <= PIO_ADDR_DATA;
          avm_writedata  <= '0;
          state          <= SETTLE;
        end
        SETTLE:  state <= IDLE;
        default: state <= INIT;
      endcase
    end
  end

  assign push      = (state == CLR) && (cap_reg != '0);
  assign evt_valid = !empty;
  assign pop       = evt_valid && evt_ready;

`ifdef BUTTON_EVT_CTRL_TIMESTAMP_EN
  localparam int FW = DATA_W + 16;
  logic [15:0] ts_cnt;
  logic [15:0] ts_cap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (state == RD_CAP) ts_cap <= ts_cnt;
    end
  end

  logic [FW-1:0] push_data;
  logic [FW-1:0] head_data;
  assign push_data = {ts_cap, cap_reg};
  assign evt_data  = head_data[DATA_W-1:0];
  assign evt_time  = head_data[FW-1:DATA_W];
`else
  localparam int FW = DATA_W;
  logic [FW-1:0] push_data;
  logic [FW-1:0] head_data;
  assign push_data = cap_reg;
  assign evt_data  = head_data;
  assign evt_time  = '0;
`endif

  button_evt_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (full),
    .empty     (empty)
  );

  // A new overflow outranks a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 ovf <= 1'b0;
    else if (push && full && !pop) ovf <= 1'b1;
    else if (ovf_clr)             ovf <= 1'b0;
  end

endmodule

// File: tb/tb_button_evt_ctrl.sv
// tb/tb_button_evt_ctrl.sv - randomized bench with a PIO model and a timeline/queue
// reference model of button_evt_ctrl
module tb_button_evt_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pio_irq;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        evt_valid;
  logic        evt_ready;
  logic [3:0]  evt_data;
  logic [15:0] evt_time;
  logic        ovf;
  logic        ovf_clr;

  always #5 clk = ~clk;

  button_evt_ctrl #(
    .DATA_W     (4),
    .MASK_INIT  (4'hF),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pio_irq        (pio_irq),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_data       (evt_data),
    .evt_time       (evt_time),
    .ovf            (ovf),
    .ovf_clr        (ovf_clr)
  );

  int vectors = 0;
  int errors  = 0;
  int checks  = 0;

  // reference model: cycle since reset release, position in the 5-cycle service
  // timeline (0 = idle), captured edge bits, event queue and sticky overflow
  int          c;
  int          pos;
  logic [3:0]  cap_m;
  logic [15:0] capt_m;
  logic [19:0] ev_q[$];
  bit          ovf_m;

  // button PIO model and the bus cycle it saw last
  logic [3:0]  edge_r;
  logic [3:0]  mask_r;
  bit          b_cs, b_wn;
  logic [1:0]  b_a;
  logic [31:0] b_d;

  bit          rand_mode, dir_ready, dir_ready_on_clr, dir_clr, dir_force;
  logic [3:0]  dir_inj;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, c);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cs"},    32'(avm_chipselect), 32'd0);
    chk({tag, "_wn"},    32'(avm_write_n),    32'd1);
    chk({tag, "_addr"},  32'(avm_address),    32'd0);
    chk({tag, "_wdata"}, avm_writedata,       32'd0);
    chk({tag, "_valid"}, 32'(evt_valid),      32'd0);
    chk({tag, "_data"},  32'(evt_data),       32'd0);
    chk({tag, "_time"},  32'(evt_time),       32'd0);
    chk({tag, "_ovf"},   32'(ovf),            32'd0);
  endtask

  task automatic model_reset();
    c = 0; pos = 0; cap_m = '0; capt_m = '0; ovf_m = 0;
    ev_q.delete();
  endtask

  task automatic compare();
    bit e_cs, e_wn;
    logic [1:0]  e_a;
    logic [31:0] e_d;
    e_cs = 0; e_wn = 1; e_a = 2'd0; e_d = 32'd0;
    if (c == 1) begin
      e_cs = 1; e_wn = 0; e_a = 2'd2; e_d = 32'h0000_000F;
    end else if (c > 1) begin
      case (pos)
        1: begin e_cs = 1; e_a = 2'd3; end
        2: e_a = 2'd3;
        3: begin e_cs = 1; e_wn = 0; e_a = 2'd3; e_d = 32'hFFFF_FFFF; end
        default: ;
      endcase
    end
    chk("bus_cs",    32'(avm_chipselect), 32'(e_cs));
    chk("bus_wn",    32'(avm_write_n),    32'(e_wn));
    chk("bus_addr",  32'(avm_address),    32'(e_a));
    chk("bus_wdata", avm_writedata,       e_d);
    chk("evt_valid", 32'(evt_valid),      32'(ev_q.size() > 0));
    if (ev_q.size() > 0) begin
      chk("evt_data", 32'(evt_data), 32'(ev_q[0][3:0]));
      chk("evt_time", 32'(evt_time), 32'(ev_q[0][19:4]));
    end
    chk("ovf", 32'(ovf), 32'(ovf_m));
  endtask

  task automatic model_advance();
    bit push, pop, ovf_set;
    logic [15:0] ts;
    if (pos == 2) begin
      cap_m  = avm_readdata[3:0];
      capt_m = 16'(c);
    end
`ifdef BUTTON_EVT_CTRL_TIMESTAMP_EN
    ts = capt_m;
`else
    ts = 16'h0;
`endif
    push    = (pos == 3) && (cap_m != 4'h0);
    pop     = (ev_q.size() > 0) && evt_ready;
    ovf_set = 0;
    if (pop) void'(ev_q.pop_front());
    if (push) begin
      if (ev_q.size() >= DEPTH) ovf_set = 1;
      else ev_q.push_back({ts, cap_m});
    end
    if (ovf_set)      ovf_m = 1;
    else if (ovf_clr) ovf_m = 0;
    if (pos == 0)      pos = (c >= 1 && pio_irq) ? 1 : 0;
    else if (pos == 4) pos = 0;
    else               pos = pos + 1;
    c++;
  endtask

  task automatic drive();
    logic [3:0] inj;
    bit frc;
    avm_readdata = {28'($urandom), (b_cs && b_wn && b_a == 2'd3) ? edge_r : 4'($urandom)};
    if (b_cs && !b_wn && b_a == 2'd2) mask_r = b_d[3:0];
    if (b_cs && !b_wn && b_a == 2'd3) edge_r = edge_r & ~b_d[3:0];
    if (rand_mode) begin
      inj       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      frc       = ($urandom_range(0, 49) == 0);
      evt_ready = ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
    end else begin
      inj       = dir_inj;
      frc       = dir_force;
      evt_ready = dir_ready_on_clr ? (pos == 3) : dir_ready;
      ovf_clr   = dir_clr;
    end
    dir_inj   = 4'h0;
    dir_force = 0;
    edge_r  = edge_r | inj;
    pio_irq = (|(edge_r & mask_r)) | frc;
  endtask

  task automatic step();
    @(negedge clk);
    vectors++;
    compare();
    b_cs = avm_chipselect; b_wn = avm_write_n; b_a = avm_address; b_d = avm_writedata;
    model_advance();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    b_cs = 0; b_wn = 1; b_a = 2'd0; b_d = 32'd0;
    step();
    chk("init_cs",    32'(avm_chipselect), 32'd1);
    chk("init_wn",    32'(avm_write_n),    32'd0);
    chk("init_addr",  32'(avm_address),    32'd2);
    chk("init_wdata", avm_writedata,       32'h0000_000F);
  endtask

  initial begin
    logic [15:0] t0, dt;
    logic [3:0]  exp_order [4];
    int guard;
    reset_n = 1'b0; pio_irq = 0; evt_ready = 0; ovf_clr = 0; avm_readdata = '0;
    edge_r = '0; mask_r = '0;
    rand_mode = 0; dir_ready = 0; dir_ready_on_clr = 0; dir_clr = 0; dir_force = 0; dir_inj = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    release_reset();
    repeat (6) step();

    // edge 0101 -> one event with data 5
    dir_inj = 4'b0101;
    repeat (8) step();
    chk("e5_valid", 32'(evt_valid), 32'd1);
    chk("e5_data",  32'(evt_data),  32'h5);
    chk("e5_model", 32'(ev_q.size()), 32'd1);

    dir_ready = 1; repeat (3) step(); dir_ready = 0; step();

    // five irqs, no consumer -> four queued, overflow
    for (int i = 0; i < 5; i++) begin
      dir_inj = 4'h1;
      repeat (8) step();
    end
    chk("ovf_set",   32'(ovf), 32'd1);
    chk("ovf_occ_m", 32'(ev_q.size()), 32'd4);
    dir_clr = 1; step(); dir_clr = 0; step();
    chk("ovf_clr", 32'(ovf), 32'd0);

    // full FIFO, push with coincident pop
    dir_ready_on_clr = 1; dir_inj = 4'h2;
    repeat (8) step();
    dir_ready_on_clr = 0;
    chk("pp_ovf",   32'(ovf), 32'd0);
    chk("pp_occ_m", 32'(ev_q.size()), 32'd4);
    exp_order = '{4'h1, 4'h1, 4'h1, 4'h2};
    dir_ready = 1; step();
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(evt_data), 32'(exp_order[i]));
      step();
    end
    chk("drain_empty", 32'(evt_valid), 32'd0);
    dir_ready = 0; step();

    // spurious irq: clear write still issued, nothing pushed
    dir_force = 1;
    repeat (8) step();
    chk("spur_valid", 32'(evt_valid), 32'd0);

`ifdef BUTTON_EVT_CTRL_TIMESTAMP_EN
    dir_inj = 4'h1; step();
    repeat (99) step();
    dir_inj = 4'h1; step();
    repeat (8) step();
    chk("ts_model", 32'(ev_q[1][19:4] - ev_q[0][19:4]), 32'd100);
    t0 = evt_time;
    dir_ready = 1; step(); dir_ready = 0; step();
    dt = evt_time - t0;
    chk("ts_diff", 32'(dt), 32'd100);
    dir_ready = 1; repeat (2) step(); dir_ready = 0; step();
`else
    t0 = '0; dt = '0;
`endif

    // reset asserted in the middle of a clear write
    dir_inj = 4'h8;
    guard = 0;
    while (pos != 3 && guard < 50) begin
      step();
      guard++;
    end
    chk("clr_reached", 32'(pos), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(posedge clk);
    release_reset();
    repeat (10) step();

    rand_mode = 1;
    repeat (3000) step();
    rand_mode = 0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/button_evt_ctrl.md
BUTTON_EVT_CTRL -- requirements
Module: button_evt_ctrl

Interface
REQ-001 Parameter DATA_W, default 4: button width and width of the PIO edge register.
REQ-002 Parameter MASK_INIT, default 4'hF: irq_mask value written at start-up.
REQ-003 Parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, 2..16.
REQ-004 clk  in  1  clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 pio_irq  in  1  level interrupt from the button PIO.
REQ-007 avm_address  out  2  PIO register select (0 data, 2 mask, 3 edge).
REQ-008 avm_chipselect  out  1  PIO access strobe.
REQ-009 avm_write_n  out  1  active-low write qualifier.
REQ-010 avm_writedata  out  32  write data.
REQ-011 avm_readdata  in  32  PIO read data, registered, one-cycle latency.
REQ-012 evt_valid  out  1  FIFO head valid.
REQ-013 evt_ready  in  1  consumer accept; a pop occurs when evt_valid and evt_ready are both high.
REQ-014 evt_data  out  DATA_W  captured edge bits at FIFO head.
REQ-015 evt_time  out  16  timestamp at FIFO head.
REQ-016 ovf  out  1  sticky overflow flag.
REQ-017 ovf_clr  in  1  clears ovf.

Function
REQ-018 FSM states SHALL be INIT, IDLE, RD_ADDR, RD_CAP, CLR and SETTLE.
REQ-019 INIT: one cycle, chipselect=1, write_n=0, address=2, writedata=MASK_INIT zero-extended; then IDLE.
REQ-020 IDLE: chipselect=0; on pio_irq=1 go to RD_ADDR.
REQ-021 RD_ADDR: chipselect=1, write_n=1, address=3; next state RD_CAP.
REQ-022 RD_CAP: address held at 3, chipselect=0; avm_readdata[DATA_W-1:0] is latched into cap_reg; next state CLR.
REQ-023 CLR: chipselect=1, write_n=0, address=3, writedata=32'hFFFFFFFF; the event is pushed in the same cycle if cap_reg≠0; next state SETTLE.
REQ-024 SETTLE: one cycle with no access, so that pio_irq reflects the cleared state; then IDLE.
REQ-025 Per irq, the bus access sequence SHALL be 5 cycles from IDLE detect to return to IDLE.
REQ-026 Edges arriving between RD_CAP and CLR are lost; this is an accepted limitation.
REQ-027 When cap_reg=0 (spurious irq), the block SHALL skip the push and still perform the clear write.
REQ-028 The FIFO SHALL be first-word fall-through: evt_valid=1 whenever the FIFO is non-empty.
REQ-029 Push while full without a simultaneous pop: the event is dropped and ovf is set.
REQ-030 Push while full with a simultaneous pop: both succeed; occupancy is unchanged; no overflow.
REQ-031 Pop while empty is ignored; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-032 ovf_clr coincident with a new overflow: set wins, so ovf stays 1.
REQ-033 avm_writedata SHALL be 0 in every state except INIT and CLR.

Reset
REQ-034 Asserted reset_n SHALL set: state=INIT, FIFO empty, evt_valid=0, evt_data=0, evt_time=0, ovf=0, chipselect=0, write_n=1, address=0, writedata=0, cap_reg=0, timestamp counter=0.
REQ-035 Reset mid-sequence abandons the access; after release the block restarts at INIT.

Configuration
REQ-036 Macro BUTTON_EVT_CTRL_TIMESTAMP_EN.
REQ-037 With the macro defined: a free-running 16-bit cycle counter wraps at 16'hFFFF, is sampled in RD_CAP, and is stored alongside each event.
REQ-038 Without the macro: no counter is built, no timestamp storage exists, and evt_time is tied to 0.

Structure
REQ-039 Package button_evt_pkg SHALL hold the state enum and the constants PIO_ADDR_DATA=0, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3.
REQ-040 The FIFO SHALL be sub-module button_evt_fifo, parameterised by width and depth, with full/empty outputs.

Verification
REQ-041 Release reset -> cycle 1: write of address 2 with data 0x0000000F; thereafter chipselect=0 while pio_irq=0.
REQ-042 pio_irq high, PIO edge register=4'b0101 -> read of address 3, write of 0xFFFFFFFF to address 3, then evt_valid=1 with evt_data=4'h5 on the cycle after CLR.
REQ-043 evt_ready=0, five irqs with edge register=1 at FIFO_DEPTH=4 -> four entries queued and ovf=1; ovf_clr -> ovf=0.
REQ-044 FIFO full, push and pop in the same cycle -> occupancy stays 4, ovf stays 0, entries are read in order.
REQ-045 pio_irq pulse with edge register=0 -> clear write issued, no push, evt_valid stays 0.
REQ-046 reset_n asserted during CLR -> outputs at reset values, and INIT mask write occurs after release; with BUTTON_EVT_CTRL_TIMESTAMP_EN, two irqs 100 cycles apart produce an evt_time difference of 100.
